// File: rtl/rtl_settings_pkg.sv
// Shared widths, command/compare bundles and the pattern LFSR step
// used by transmit_block and compare_block.
package rtl_settings_pkg;

  localparam int AMM_ADDR_W  = 31;
  localparam int AMM_DATA_W  = 128;
  localparam int AMM_BURST_W = 11;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } op_t;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } data_mode_t;

  typedef struct packed {
    op_t                    op;
    logic [AMM_ADDR_W-1:0]  start_addr;
    logic [AMM_BURST_W-1:0] words_count;
    data_mode_t             data_mode;
    logic [7:0]             data_ptrn;
  } trans_struct_t;

  typedef struct packed {
    logic [AMM_ADDR_W-1:0]  start_addr;
    logic [AMM_BURST_W-1:0] words_count;
    data_mode_t             data_mode;
    logic [7:0]             data_ptrn;
  } cmp_struct_t;

  function automatic logic [7:0] ptrn_next(input logic [7:0] p);
    return {p[6:0], p[6] ^ p[1] ^ p[0]};
  endfunction

endpackage

// File: rtl/ptrn_gen.sv
// Byte pattern register: loads a seed, steps the LFSR on demand,
// and replicates the current byte across the data bus.
module ptrn_gen
  import rtl_settings_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [7:0]            seed_i,
  input  logic                  adv_i,
  output logic [AMM_DATA_W-1:0] data_o
);

  logic [7:0] ptrn;

  // Load wins over advance; they never coincide in practice.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptrn <= '0;
    end else if (load_i) begin
      ptrn <= seed_i;
    end else if (adv_i) begin
      ptrn <= ptrn_next(ptrn);
    end
  end

  assign data_o = {(AMM_DATA_W/8){ptrn}};

endmodule

// File: rtl/transmit_block.sv
// Avalon-MM burst master: turns test commands into write/read bursts
// and hands read descriptors to compare_block.
module transmit_block
  import rtl_settings_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    test_start_i,
  input  logic                    cmd_valid_i,
  input  trans_struct_t           cmd_i,
  output logic                    cmd_ready_o,
  output logic [AMM_ADDR_W-1:0]   address_o,
  output logic                    read_o,
  output logic                    write_o,
  output logic [AMM_BURST_W-1:0]  burstcount_o,
  output logic [AMM_DATA_W-1:0]   writedata_o,
  output logic [AMM_DATA_W/8-1:0] byteenable_o,
  input  logic                    waitrequest_i,
  input  logic                    cmp_ready_i,
  input  logic                    cmp_error_i,
  output logic                    cmp_en_o,
  output cmp_struct_t             cmp_struct_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    IDLE_S,
    WRITE_S,
    RD_WAIT_S,
    READ_S
  } state_t;

  state_t                 state;
  logic                   err_lock;
  logic [AMM_BURST_W-1:0] beat_cnt;
  cmp_struct_t            cap;
  logic                   accept;
  logic                   beat_ok;

  assign cmd_ready_o  = (state == IDLE_S) && !err_lock && !test_start_i;
  assign accept       = cmd_ready_o && cmd_valid_i;
  assign beat_ok      = write_o && !waitrequest_i;
  assign byteenable_o = '1;

  ptrn_gen u_ptrn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .seed_i (cmd_i.data_ptrn),
    .adv_i  (beat_ok && (cap.data_mode == RND_DATA)),
    .data_o (writedata_o)
  );

  // Error lock: restart beats a simultaneous error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_lock <= 1'b0;
    end else if (test_start_i) begin
      err_lock <= 1'b0;
    end else if (cmp_error_i) begin
      err_lock <= 1'b1;
    end
  end

  // Burst FSM with registered Avalon and compare outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE_S;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      cmp_en_o     <= 1'b0;
      busy_o       <= 1'b0;
      address_o    <= '0;
      burstcount_o <= '0;
      beat_cnt     <= '0;
      cap          <= '0;
      cmp_struct_o <= '0;
    end else begin
      cmp_en_o <= 1'b0;
      unique case (state)
        IDLE_S: begin
          if (accept) begin
            cap.start_addr  <= cmd_i.start_addr;
            cap.words_count <= cmd_i.words_count;
            cap.data_mode   <= cmd_i.data_mode;
            cap.data_ptrn   <= cmd_i.data_ptrn;
            beat_cnt        <= cmd_i.words_count;
            address_o       <= cmd_i.start_addr;
            burstcount_o    <= cmd_i.words_count + AMM_BURST_W'(1);
            busy_o          <= 1'b1;
            if (cmd_i.op == WRITE) begin
              write_o <= 1'b1;
              state   <= WRITE_S;
            end else begin
              state <= RD_WAIT_S;
            end
          end
        end
        WRITE_S: begin
          if (!waitrequest_i) begin
            if (beat_cnt == '0) begin
              write_o <= 1'b0;
              busy_o  <= 1'b0;
              state   <= IDLE_S;
            end else begin
              beat_cnt <= beat_cnt - AMM_BURST_W'(1);
            end
          end
        end
        RD_WAIT_S: begin
          if (err_lock) begin
            busy_o <= 1'b0;
            state  <= IDLE_S;
          end else if (cmp_ready_i) begin
            read_o <= 1'b1;
            state  <= READ_S;
          end
        end
        READ_S: begin
          if (!waitrequest_i) begin
            read_o       <= 1'b0;
            cmp_en_o     <= 1'b1;
            cmp_struct_o <= cap;
            busy_o       <= 1'b0;
            state        <= IDLE_S;
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_transmit_block.sv
// Scoreboard bench for transmit_block: expected beats, reads and
// compare descriptors are queued at stimulus time and popped on output.
module tb_transmit_block;
  import rtl_settings_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    test_start_i = 1'b0;
  logic                    cmd_valid_i = 1'b0;
  trans_struct_t           cmd_i = '0;
  logic                    cmd_ready_o;
  logic [AMM_ADDR_W-1:0]   address_o;
  logic                    read_o;
  logic                    write_o;
  logic [AMM_BURST_W-1:0]  burstcount_o;
  logic [AMM_DATA_W-1:0]   writedata_o;
  logic [AMM_DATA_W/8-1:0] byteenable_o;
  logic                    waitrequest_i = 1'b0;
  logic                    cmp_ready_i = 1'b1;
  logic                    cmp_error_i = 1'b0;
  logic                    cmp_en_o;
  cmp_struct_t             cmp_struct_o;
  logic                    busy_o;

  transmit_block dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .test_start_i  (test_start_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_i         (cmd_i),
    .cmd_ready_o   (cmd_ready_o),
    .address_o     (address_o),
    .read_o        (read_o),
    .write_o       (write_o),
    .burstcount_o  (burstcount_o),
    .writedata_o   (writedata_o),
    .byteenable_o  (byteenable_o),
    .waitrequest_i (waitrequest_i),
    .cmp_ready_i   (cmp_ready_i),
    .cmp_error_i   (cmp_error_i),
    .cmp_en_o      (cmp_en_o),
    .cmp_struct_o  (cmp_struct_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AMM_ADDR_W-1:0]  a;
    logic [AMM_BURST_W-1:0] bc;
    logic [AMM_DATA_W-1:0]  d;
  } beat_t;

  beat_t       wq[$];
  beat_t       rq[$];
  cmp_struct_t cq[$];

  int errs   = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int cm_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nx(input logic [7:0] b);
    logic [7:0] r;
    r[7:1] = b[6:0];
    r[0]   = b[6] ^ b[1] ^ b[0];
    return r;
  endfunction

  function automatic logic [AMM_DATA_W-1:0] rep(input logic [7:0] b);
    logic [AMM_DATA_W-1:0] r;
    for (int i = 0; i < AMM_DATA_W/8; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  function automatic trans_struct_t mk(input op_t op, input int addr,
                                       input int wc, input data_mode_t m,
                                       input logic [7:0] p);
    trans_struct_t c;
    c.op          = op;
    c.start_addr  = AMM_ADDR_W'(addr);
    c.words_count = AMM_BURST_W'(wc);
    c.data_mode   = m;
    c.data_ptrn   = p;
    return c;
  endfunction

  task automatic push_wr(input int addr, input int wc, input data_mode_t m,
                         input logic [7:0] p0, input int nbeats);
    beat_t      e;
    logic [7:0] p;
    p = p0;
    for (int k = 0; k < nbeats; k++) begin
      e.a  = AMM_ADDR_W'(addr);
      e.bc = AMM_BURST_W'(wc + 1);
      e.d  = rep(p);
      wq.push_back(e);
      if (m == RND_DATA) p = nx(p);
    end
  endtask

  task automatic push_rd(input int addr, input int wc, input data_mode_t m,
                         input logic [7:0] p);
    beat_t       e;
    cmp_struct_t c;
    e.a  = AMM_ADDR_W'(addr);
    e.bc = AMM_BURST_W'(wc + 1);
    e.d  = '0;
    rq.push_back(e);
    c.start_addr  = AMM_ADDR_W'(addr);
    c.words_count = AMM_BURST_W'(wc);
    c.data_mode   = m;
    c.data_ptrn   = p;
    cq.push_back(c);
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input trans_struct_t c);
    int n;
    cmd_i       = c;
    cmd_valid_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (!cmd_ready_o) chk("send_to", 1'b0, 1'b1);
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < lim) begin
      n++;
      @(negedge clk_i);
    end
    if (busy_o) chk("idle_to", busy_o, 1'b0);
    @(negedge clk_i);
  endtask

  // Output monitor: every accepted beat/read and every compare push
  // must match the head of its queue.
  always @(negedge clk_i) begin
    beat_t       e;
    cmp_struct_t c;
    if (!rst_i) begin
      if (write_o && !waitrequest_i) begin
        wr_cnt++;
        if (wq.size() == 0) chk("wr_unexp", 1'b1, 1'b0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", address_o, e.a);
          chk("wr_bc", burstcount_o, e.bc);
          chk("wr_data", writedata_o, e.d);
        end
      end
      if (read_o && !waitrequest_i) begin
        rd_cnt++;
        if (rq.size() == 0) chk("rd_unexp", 1'b1, 1'b0);
        else begin
          e = rq.pop_front();
          chk("rd_addr", address_o, e.a);
          chk("rd_bc", burstcount_o, e.bc);
        end
      end
      if (cmp_en_o) begin
        cm_cnt++;
        if (cq.size() == 0) chk("cmp_unexp", 1'b1, 1'b0);
        else begin
          c = cq.pop_front();
          chk("cmp_struct", cmp_struct_o, c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int w0, r0, c0;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", cmd_ready_o, 1'b1);
    chk("rst_write", write_o, 1'b0);
    chk("rst_read", read_o, 1'b0);
    chk("rst_cmp_en", cmp_en_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_addr", address_o, '0);
    chk("rst_bc", burstcount_o, '0);
    chk("rst_wdata", writedata_o, '0);
    chk("rst_cmps", cmp_struct_o, '0);
    chk("rst_be", byteenable_o, {(AMM_DATA_W/8){1'b1}});
    @(posedge clk_i);
    #1;

    // Fixed-data write, no stalls
    w0 = wr_cnt;
    push_wr(32'h100, 3, FIX_DATA, 8'hA5, 4);
    send(mk(WRITE, 32'h100, 3, FIX_DATA, 8'hA5));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("fix_wr_high", write_o, 1'b1);
      chk("fix_ready_lo", cmd_ready_o, 1'b0);
    end
    @(negedge clk_i);
    chk("fix_wr_low", write_o, 1'b0);
    chk("fix_ready_back", cmd_ready_o, 1'b1);
    chk("fix_beats", wr_cnt - w0, 4);
    @(posedge clk_i);
    #1;

    // Random-data write with a stall on beat 1
    w0 = wr_cnt;
    push_wr(32'h180, 2, RND_DATA, 8'h01, 3);
    send(mk(WRITE, 32'h180, 2, RND_DATA, 8'h01));
    @(posedge clk_i);
    #1 waitrequest_i = 1'b1;
    @(negedge clk_i);
    chk("stall_data", writedata_o, rep(8'h03));
    @(posedge clk_i);
    #1 waitrequest_i = 1'b0;
    @(negedge clk_i);
    chk("stall_hold", writedata_o, rep(8'h03));
    chk("stall_wr", write_o, 1'b1);
    wait_idle(20);
    chk("rnd_beats", wr_cnt - w0, 3);
    @(posedge clk_i);
    #1;

    // Read with compare FIFO back-pressure
    r0 = rd_cnt;
    c0 = cm_cnt;
    cmp_ready_i = 1'b0;
    push_rd(32'h40, 7, FIX_DATA, 8'h3C);
    send(mk(READ, 32'h40, 7, FIX_DATA, 8'h3C));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("rd_wait_lo", read_o, 1'b0);
    end
    @(posedge clk_i);
    #1 cmp_ready_i = 1'b1;
    wait_idle(20);
    chk("rd_count", rd_cnt - r0, 1);
    chk("cmp_count", cm_cnt - c0, 1);
    @(posedge clk_i);
    #1;

    // Compare error mid-write: burst completes, then locked
    w0 = wr_cnt;
    push_wr(32'h300, 3, FIX_DATA, 8'h5A, 4);
    send(mk(WRITE, 32'h300, 3, FIX_DATA, 8'h5A));
    @(posedge clk_i);
    #1 cmp_error_i = 1'b1;
    @(posedge clk_i);
    #1 cmp_error_i = 1'b0;
    wait_idle(20);
    chk("err_beats", wr_cnt - w0, 4);
    chk("err_ready_lo", cmd_ready_o, 1'b0);
    r0 = rd_cnt;
    c0 = cm_cnt;
    cmd_i       = mk(READ, 32'h80, 1, FIX_DATA, 8'h11);
    cmd_valid_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("err_busy", busy_o, 1'b0);
    chk("err_no_rd", rd_cnt - r0, 0);
    chk("err_no_cmp", cm_cnt - c0, 0);
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    test_start_i = 1'b1;
    @(negedge clk_i);
    chk("ts_ready_lo", cmd_ready_o, 1'b0);
    @(posedge clk_i);
    #1 test_start_i = 1'b0;
    @(negedge clk_i);
    chk("ts_ready_hi", cmd_ready_o, 1'b1);
    @(posedge clk_i);
    #1;

    // Error lock while waiting for the compare FIFO
    r0 = rd_cnt;
    c0 = cm_cnt;
    cmp_ready_i = 1'b0;
    send(mk(READ, 32'h80, 1, FIX_DATA, 8'h11));
    @(posedge clk_i);
    #1 cmp_error_i = 1'b1;
    @(posedge clk_i);
    #1 cmp_error_i = 1'b0;
    cmp_ready_i = 1'b1;
    wait_idle(20);
    repeat (3) @(negedge clk_i);
    chk("lk_no_rd", rd_cnt - r0, 0);
    chk("lk_no_cmp", cm_cnt - c0, 0);
    chk("lk_ready_lo", cmd_ready_o, 1'b0);
    @(posedge clk_i);
    #1 test_start_i = 1'b1;
    @(posedge clk_i);
    #1 test_start_i = 1'b0;

    // Maximum burst length
    w0 = wr_cnt;
    push_wr(32'h1000, 1023, RND_DATA, 8'h81, 1024);
    send(mk(WRITE, 32'h1000, 1023, RND_DATA, 8'h81));
    @(negedge clk_i);
    chk("max_bc", burstcount_o, 11'd1024);
    wait_idle(1100);
    chk("max_beats", wr_cnt - w0, 1024);
    @(posedge clk_i);
    #1;

    // Asynchronous reset mid-burst
    push_wr(32'h500, 7, FIX_DATA, 8'h11, 2);
    send(mk(WRITE, 32'h500, 7, FIX_DATA, 8'h11));
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_write", write_o, 1'b0);
    chk("ar_busy", busy_o, 1'b0);
    chk("ar_addr", address_o, '0);
    chk("ar_bc", burstcount_o, '0);
    chk("ar_wdata", writedata_o, '0);
    chk("ar_read", read_o, 1'b0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    w0 = wr_cnt;
    push_wr(32'h200, 1, FIX_DATA, 8'h77, 2);
    send(mk(WRITE, 32'h200, 1, FIX_DATA, 8'h77));
    wait_idle(20);
    chk("post_rst_beats", wr_cnt - w0, 2);

    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("cq_empty", cq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
